// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage encodings and reset PC default
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_J   = 2'b10,
    PC_JR  = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    HOLD = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/npc_select.sv
// rtl/npc_select.sv - next-PC mux with branch adder and jr alignment check
module npc_select
  import cpu_pkg::*;
(
  input  logic [1:0]  pc_sel,
  input  logic [31:0] pc_plus4,
  input  logic [15:0] branch_imm,
  input  logic [31:0] jump_target,
  input  logic [31:0] rs_data,
  output logic [31:0] next_pc,
  output logic        jr_misalign
);

  logic [31:0] br_offset;

  // Word offset becomes a byte offset; sign bit fills the upper 14 bits.
  assign br_offset = {{14{branch_imm[15]}}, branch_imm, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    case (pc_sel)
      PC_SEQ:  next_pc = pc_plus4;
      PC_BR:   next_pc = pc_plus4 + br_offset;
      PC_J:    next_pc = jump_target;
      PC_JR:   next_pc = {rs_data[31:2], 2'b00};
      default: next_pc = pc_plus4;
    endcase
  end

  assign jr_misalign = (pc_sel == PC_JR) && (rs_data[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter, req/ack fetch FSM and held instruction
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  pc_sel,
  input  logic [15:0] branch_imm,
  input  logic [31:0] jump_target,
  input  logic [31:0] rs_data,
  input  logic        stall,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_plus4,
  output logic [3:0]  pc31_28,
  output logic        jr_misalign
);

  fetch_state_e state, state_next;
  logic [31:0]  pc;
  logic [31:0]  pc_inc;
  logic [31:0]  next_pc;
  logic         npc_misalign;
  logic         fetch_done;
  logic         consume;

  npc_select u_npc_select (
    .pc_sel      (pc_sel),
    .pc_plus4    (pc_plus4),
    .branch_imm  (branch_imm),
    .jump_target (jump_target),
    .rs_data     (rs_data),
    .next_pc     (next_pc),
    .jr_misalign (npc_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    fetch_done = 1'b0;
    consume    = 1'b0;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          fetch_done = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        inst_valid = 1'b1;
        if (!stall) begin
          consume    = 1'b1;
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign pc_inc    = pc + 32'd4;
  assign imem_addr = pc;

  // pc_plus4 is registered alongside inst_pc so it only moves on a fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inst        <= '0;
      inst_pc     <= '0;
      pc_plus4    <= 32'd4;
      pc31_28     <= '0;
      jr_misalign <= 1'b0;
    end else begin
      jr_misalign <= consume & npc_misalign;
      if (fetch_done) begin
        inst     <= imem_rdata;
        inst_pc  <= pc;
        pc_plus4 <= pc_inc;
        pc31_28  <= pc_inc[31:28];
      end
      if (consume) pc <= next_pc;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - randomized self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pc_sel;
  logic [15:0] branch_imm;
  logic [31:0] jump_target;
  logic [31:0] rs_data;
  logic        stall;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic [3:0]  pc31_28;
  logic        jr_misalign;

  int vecs = 0;
  int errs = 0;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_sel(pc_sel), .branch_imm(branch_imm),
    .jump_target(jump_target), .rs_data(rs_data), .stall(stall),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_req(imem_req),
    .imem_addr(imem_addr), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .pc_plus4(pc_plus4), .pc31_28(pc31_28),
    .jr_misalign(jr_misalign)
  );

  always #5 clk = ~clk;

  // Reference model: "fetching" / "holding" phases plus architectural values.
  bit          m_started, m_fetching, m_holding, m_mis;
  logic [31:0] m_pc, m_inst, m_inst_pc;

  logic [134:0] obs;
  assign obs = {imem_req, imem_addr, inst_valid, inst, inst_pc, pc_plus4, pc31_28, jr_misalign};

  function automatic logic [134:0] exp_vec();
    logic [31:0] p4;
    p4 = m_inst_pc + 32'd4;
    return {m_fetching, m_pc, m_holding, m_inst, m_inst_pc, p4, p4[31:28], m_mis};
  endfunction

  task automatic model_reset();
    m_started = 0; m_fetching = 0; m_holding = 0; m_mis = 0;
    m_pc = 32'h0040_0000; m_inst = 0; m_inst_pc = 0;
  endtask

  task automatic model_edge();
    int off;
    m_mis = 0;
    if (!m_started) begin
      m_started = 1; m_fetching = 1;
    end else if (m_fetching) begin
      if (imem_ack) begin
        m_inst = imem_rdata; m_inst_pc = m_pc;
        m_fetching = 0; m_holding = 1;
      end
    end else if (m_holding && !stall) begin
      case (pc_sel)
        2'd0: m_pc = m_inst_pc + 32'd4;
        2'd1: begin
          off  = int'($signed(branch_imm)) * 4;
          m_pc = m_inst_pc + 32'd4 + 32'(off);
        end
        2'd2: m_pc = jump_target;
        default: begin
          m_pc  = rs_data & ~32'd3;
          m_mis = (rs_data % 4) != 0;
        end
      endcase
      m_holding = 0; m_fetching = 1;
    end
  endtask

  task automatic set_in(input logic [1:0] sel, input logic [15:0] imm, input logic [31:0] jt,
                        input logic [31:0] rs, input logic st, input logic ack, input logic [31:0] rd);
    pc_sel = sel; branch_imm = imm; jump_target = jt; rs_data = rs;
    stall = st; imem_ack = ack; imem_rdata = rd;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic fetch(input logic [31:0] rd);
    set_in(2'd0, 16'h0, 32'h0, 32'h0, 1'b1, 1'b1, rd);
    cyc();
  endtask

  task automatic consume(input logic [1:0] sel, input logic [15:0] imm, input logic [31:0] jt,
                         input logic [31:0] rs);
    set_in(sel, imm, jt, rs, 1'b0, 1'b0, 32'h0);
    cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    set_in(2'd3, 16'h1234, 32'hDEAD_BEEF, 32'h1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    repeat (3) cyc();
    vecs++;
    if (obs !== exp_vec()) begin
      $display("FAIL reset_state got=%h exp=%h", obs, exp_vec()); errs++;
    end
    vecs++;
    if (pc_plus4 !== 32'd4 || imem_addr !== 32'h0040_0000 || imem_req !== 1'b0) begin
      $display("FAIL reset_consts pc_plus4=%h addr=%h req=%b exp 4/00400000/0", pc_plus4, imem_addr, imem_req); errs++;
    end
  endtask

  task automatic test_first_fetch();
    rst_n = 1'b1;
    set_in(2'd0, 16'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc();
    vecs++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin
      $display("FAIL first_req req=%b addr=%h exp 1/00400000", imem_req, imem_addr); errs++;
    end
    fetch(32'h2408_0005);
    vecs++;
    if (inst_valid !== 1'b1 || inst !== 32'h2408_0005 || pc_plus4 !== 32'h0040_0004 || pc31_28 !== 4'h0
        || imem_req !== 1'b0) begin
      $display("FAIL first_hold valid=%b inst=%h p4=%h p31=%h req=%b exp 1/24080005/00400004/0/0",
               inst_valid, inst, pc_plus4, pc31_28, imem_req); errs++;
    end
    vecs++;
    if (obs !== exp_vec()) begin
      $display("FAIL first_model got=%h exp=%h", obs, exp_vec()); errs++;
    end
  endtask

  task automatic test_branch();
    consume(2'd2, 16'h0, 32'h0040_0010, 32'h0);
    fetch(32'h1000_FFFC);
    consume(2'd1, 16'hFFFC, 32'h0, 32'h0);
    vecs++;
    if (imem_addr !== 32'h0040_0004 || obs !== exp_vec()) begin
      $display("FAIL branch_back addr=%h exp=00400004 (model %h)", imem_addr, exp_vec()); errs++;
    end
    fetch(32'h0);
    consume(2'd2, 16'h0, 32'h0040_0010, 32'h0);
    fetch(32'h1000_0003);
    consume(2'd1, 16'h0003, 32'h0, 32'h0);
    vecs++;
    if (imem_addr !== 32'h0040_0020 || obs !== exp_vec()) begin
      $display("FAIL branch_fwd addr=%h exp=00400020", imem_addr); errs++;
    end
  endtask

  task automatic test_jump();
    fetch(32'h0810_0040);
    consume(2'd2, 16'h0, 32'h0040_0100, 32'h0);
    vecs++;
    if (imem_addr !== 32'h0040_0100 || jr_misalign !== 1'b0) begin
      $display("FAIL jump addr=%h mis=%b exp 00400100/0", imem_addr, jr_misalign); errs++;
    end
    fetch(32'h03E0_0008);
    consume(2'd3, 16'h0, 32'h0, 32'h0040_0203);
    vecs++;
    if (imem_addr !== 32'h0040_0200 || jr_misalign !== 1'b1) begin
      $display("FAIL jr addr=%h mis=%b exp 00400200/1", imem_addr, jr_misalign); errs++;
    end
    set_in(2'd3, 16'h0, 32'h0, 32'h0040_0203, 1'b0, 1'b0, 32'h0);
    cyc();
    vecs++;
    if (jr_misalign !== 1'b0 || obs !== exp_vec()) begin
      $display("FAIL jr_pulse_len mis=%b exp 0", jr_misalign); errs++;
    end
  endtask

  task automatic test_stall();
    logic [31:0] tgt;
    fetch(32'hAAAA_5555);
    for (int i = 0; i < 5; i++) begin
      set_in(2'(i), 16'($urandom), $urandom, $urandom, 1'b1, 1'($urandom), $urandom);
      cyc();
      vecs++;
      if (obs !== exp_vec() || imem_req !== 1'b0 || inst !== 32'hAAAA_5555) begin
        $display("FAIL stall_%0d got=%h exp=%h", i, obs, exp_vec()); errs++;
      end
    end
    tgt = $urandom & ~32'd3;
    consume(2'd2, 16'h0001, tgt, 32'h0);
    vecs++;
    if (imem_addr !== tgt || imem_req !== 1'b1) begin
      $display("FAIL stall_release addr=%h req=%b exp %h/1", imem_addr, imem_req, tgt); errs++;
    end
  endtask

  task automatic test_delayed_ack();
    logic [31:0] addr0;
    addr0 = m_pc;
    for (int i = 0; i < 4; i++) begin
      set_in(2'(i), 16'($urandom), $urandom, $urandom, 1'($urandom), 1'b0, $urandom);
      cyc();
      vecs++;
      if (imem_req !== 1'b1 || imem_addr !== addr0 || inst_valid !== 1'b0) begin
        $display("FAIL wait_%0d req=%b addr=%h exp 1/%h", i, imem_req, imem_addr, addr0); errs++;
      end
    end
    fetch(32'h1357_9BDF);
    set_in(2'd2, 16'h0, 32'h1111_1110, 32'h0, 1'b1, 1'b1, 32'h2468_ACE0);
    cyc();
    vecs++;
    if (inst !== 32'h1357_9BDF || inst_pc !== addr0 || obs !== exp_vec()) begin
      $display("FAIL spurious_ack inst=%h pc=%h exp 13579bdf/%h", inst, inst_pc, addr0); errs++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in(2'($urandom), 16'($urandom), $urandom, $urandom,
             ($urandom_range(0, 3) == 0), 1'($urandom), $urandom);
      cyc();
      vecs++;
      if (obs !== exp_vec()) begin
        $display("FAIL random_%0d got=%h exp=%h", i, obs, exp_vec()); errs++;
      end
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    while (!m_fetching && guard < 10) begin
      consume(2'd0, 16'h0, 32'h0, 32'h0);
      guard++;
    end
    vecs++;
    if (imem_req !== 1'b1) begin
      $display("FAIL pre_reset_req got=%b exp 1", imem_req); errs++;
    end
    set_in(2'd0, 16'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    vecs++;
    if (obs !== exp_vec() || imem_req !== 1'b0) begin
      $display("FAIL async_reset got=%h exp=%h", obs, exp_vec()); errs++;
    end
    cyc();
    vecs++;
    if (inst !== 32'h0 || inst_valid !== 1'b0 || imem_addr !== 32'h0040_0000) begin
      $display("FAIL reset_ack inst=%h valid=%b addr=%h exp 0/0/00400000", inst, inst_valid, imem_addr); errs++;
    end
    rst_n = 1'b1;
    set_in(2'd0, 16'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc();
    fetch(32'h0000_0001);
    vecs++;
    if (obs !== exp_vec()) begin
      $display("FAIL post_reset got=%h exp=%h", obs, exp_vec()); errs++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(2'd0, 16'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    test_reset();
    test_first_fetch();
    test_branch();
    test_jump();
    test_stall();
    test_delayed_ack();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
